// File: rtl/parking_sensor_if.sv
// Loop-detector bundle between the car park front end and its environment.
// master: drives raw loop inputs, observes the conditioned outputs.
// slave:  the conditioner itself.
interface parking_sensor_if;
  logic raw_entry;
  logic raw_exit;
  logic sense_entry;
  logic sense_exit;
  logic entry_busy;
  logic exit_busy;
  logic fault_entry;
  logic fault_exit;

  modport master (
    output raw_entry, raw_exit,
    input  sense_entry, sense_exit, entry_busy, exit_busy, fault_entry, fault_exit
  );

  modport slave (
    input  raw_entry, raw_exit,
    output sense_entry, sense_exit, entry_busy, exit_busy, fault_entry, fault_exit
  );
endinterface

// File: rtl/parking_sensor_conditioner.sv
// Car park front end: synchronises and debounces the entry/exit loop
// detectors, qualifies one event per vehicle and issues mutually exclusive
// single-cycle sense pulses (entry has priority, exit deferred one cycle).
// Optional stuck-loop detection: PARKING_SENSOR_STUCK_DETECT_EN.

module parking_sensor_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
  , parameter int unsigned STUCK_CYCLES  = 200
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic qual,
  output logic busy,
  output logic fault
);
  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESENT
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
    , FAULT
`endif
  } state_t;

  localparam logic [7:0] DLAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [1:0] sync;
  logic [7:0] dcnt;
  logic       s;

  assign s = sync[1];

`ifdef PARKING_SENSOR_STUCK_DETECT_EN
  localparam logic [7:0] STUCK = 8'(STUCK_CYCLES);
  logic [7:0] ocnt;
  logic       fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], raw};
  end

  // Lane FSM: debounced arrival/release, qualification pulse, busy/fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= '0;
      qual  <= 1'b0;
      busy  <= 1'b0;
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
      ocnt    <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      qual <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARMING;
            dcnt  <= 8'd1;
            busy  <= 1'b1;
          end
        end
        ARMING: begin
          if (!s) begin
            state <= IDLE;
            dcnt  <= '0;
            busy  <= 1'b0;
          end else if (dcnt == DLAST) begin
            state <= PRESENT;
            qual  <= 1'b1;
            dcnt  <= '0;
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
            ocnt  <= '0;
`endif
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
        PRESENT, FAULT: begin
`else
        PRESENT: begin
`endif
          // Release takes precedence over faulting; the drop-out count
          // carries across PRESENT->FAULT so release timing is unaffected.
          if (!s && dcnt == DLAST) begin
            state <= IDLE;
            dcnt  <= '0;
            busy  <= 1'b0;
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
            fault_q <= 1'b0;
`endif
          end else begin
            dcnt <= s ? 8'd0 : dcnt + 8'd1;
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
            if (state == PRESENT && ocnt == STUCK) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
`endif
          end
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
          if (ocnt != 8'hFF) ocnt <= ocnt + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module parking_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 200
) (
  input  logic              clk,
  input  logic              rst,
  parking_sensor_if.slave   bus
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES < 1 ||
      STUCK_CYCLES > 255 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("parking_sensor_conditioner: illegal DEBOUNCE_CYCLES/STUCK_CYCLES");
  end

  logic       qual_entry;
  logic       qual_exit;
  logic [1:0] pend;
  logic [1:0] req;

  parking_sensor_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
    , .STUCK_CYCLES  (STUCK_CYCLES)
`endif
  ) u_entry (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.raw_entry),
    .qual  (qual_entry),
    .busy  (bus.entry_busy),
    .fault (bus.fault_entry)
  );

  parking_sensor_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
    , .STUCK_CYCLES  (STUCK_CYCLES)
`endif
  ) u_exit (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.raw_exit),
    .qual  (qual_exit),
    .busy  (bus.exit_busy),
    .fault (bus.fault_exit)
  );

  // Pending flags are the registered qualification pulses plus anything
  // left over from the previous cycle; bit 0 entry, bit 1 exit.
  assign req = pend | {qual_exit, qual_entry};

  // Priority arbiter: entry first, a colliding exit waits one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend            <= '0;
      bus.sense_entry <= 1'b0;
      bus.sense_exit  <= 1'b0;
    end else begin
      bus.sense_entry <= req[0];
      bus.sense_exit  <= req[1] & ~req[0];
      pend            <= req[0] ? {req[1], 1'b0} : 2'b00;
    end
  end
endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Randomised scoreboard bench for parking_sensor_conditioner.
// A run-length reference model predicts pulses and busy/fault levels per
// edge; a negedge monitor pops and compares against the DUT.
module tb_parking_sensor_conditioner;
  localparam int D = 4;
  localparam int S = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  parking_sensor_if bus ();

  parking_sensor_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .STUCK_CYCLES    (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; bit lane; } pulse_t;
  typedef struct { int unsigned cyc; bit be; bit bx; bit fe; bit fx; } stat_t;

  pulse_t pq[$];
  stat_t  sq[$];
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: raw-to-s delay line and run lengths of s.
  bit sy1[2], sy2[2], occ[2], flt[2], pend[2], bexp[2];
  int run1[2], run0[2], age[2];

  always @(posedge clk) begin
    bit raw[2];
    bit s;
    stat_t st;
    cyc++;
    raw[0] = bus.raw_entry;
    raw[1] = bus.raw_exit;
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        sy1[l] = 0; sy2[l] = 0; occ[l] = 0; flt[l] = 0; pend[l] = 0;
        bexp[l] = 0; run1[l] = 0; run0[l] = 0; age[l] = 0;
      end
    end else begin
      if (pend[0]) begin
        pq.push_back('{cyc, 1'b0});
        pend[0] = 0;
      end else if (pend[1]) begin
        pq.push_back('{cyc, 1'b1});
        pend[1] = 0;
      end
      for (int l = 0; l < 2; l++) begin
        s = sy2[l];
        sy2[l] = sy1[l];
        sy1[l] = raw[l];
        if (s) begin run1[l]++; run0[l] = 0; end
        else   begin run0[l]++; run1[l] = 0; end
        if (!occ[l]) begin
          if (run1[l] == D) begin occ[l] = 1; age[l] = 0; pend[l] = 1; end
        end else begin
          age[l]++;
          if (run0[l] == D) begin
            occ[l] = 0;
            flt[l] = 0;
          end
`ifdef PARKING_SENSOR_STUCK_DETECT_EN
          else if (!flt[l] && age[l] == S + 1) flt[l] = 1;
`endif
        end
        bexp[l] = occ[l] || s;
      end
    end
    st.cyc = cyc; st.be = bexp[0]; st.bx = bexp[1]; st.fe = flt[0]; st.fx = flt[1];
    sq.push_back(st);
  end

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    stat_t st;
    bit dl;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_checks++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL status_queue: no expectation at cycle %0d", cyc);
      end else begin
        st = sq.pop_front();
        if ({bus.entry_busy, bus.exit_busy, bus.fault_entry, bus.fault_exit} !==
            {st.be, st.bx, st.fe, st.fx}) begin
          n_fail++;
          $display("FAIL status cyc=%0d: busy_e/busy_x/fault_e/fault_x got %b%b%b%b want %b%b%b%b",
                   st.cyc, bus.entry_busy, bus.exit_busy, bus.fault_entry, bus.fault_exit,
                   st.be, st.bx, st.fe, st.fx);
        end
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_pulse: lane %0d expected at cycle %0d, still absent at cycle %0d",
                 pq[0].lane, pq[0].cyc, cyc);
        void'(pq.pop_front());
      end
      if (bus.sense_entry === 1'b1 || bus.sense_exit === 1'b1) begin
        n_checks++;
        if (bus.sense_entry === 1'b1 && bus.sense_exit === 1'b1) begin
          n_fail++;
          $display("FAIL exclusive cyc=%0d: sense_entry=1 sense_exit=1, want at most one", cyc);
        end
        dl = (bus.sense_entry === 1'b1) ? 1'b0 : 1'b1;
        n_checks++;
        if (pq.size() == 0 || pq[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d: lane %0d pulsed, no pulse expected", cyc, dl);
        end else begin
          if (pq[0].lane != dl) begin
            n_fail++;
            $display("FAIL pulse_lane cyc=%0d: got lane %0d want lane %0d", cyc, dl, pq[0].lane);
          end
          void'(pq.pop_front());
        end
      end
    end
  end

  task automatic drive(input int n, input bit e, input bit x);
    bus.raw_entry = e;
    bus.raw_exit  = x;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int hold[2];
    bit lvl[2];
    bus.raw_entry = 1'b0;
    bus.raw_exit  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Clean entry, then exit glitch, then a dip while present.
    drive(20, 1, 0);  drive(12, 0, 0);
    drive(3, 0, 1);   drive(12, 0, 0);
    drive(10, 0, 1);  drive(2, 0, 0);  drive(10, 0, 1);  drive(12, 0, 0);
    // Simultaneous arrivals.
    drive(15, 1, 1);  drive(12, 0, 0);
    // Stuck entry loop.
    drive(100, 1, 0); drive(12, 0, 0);
    // Reset while the entry lane is arming.
    drive(4, 1, 0);
    rst = 1'b1;
    drive(1, 1, 0);
    rst = 1'b0;
    drive(15, 1, 0);  drive(12, 0, 0);

    // Random traffic with occasional long occupancy and rare resets.
    lvl[0] = 0; lvl[1] = 0; hold[0] = 1; hold[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < 2; l++) begin
        hold[l]--;
        if (hold[l] <= 0) begin
          lvl[l] = ~lvl[l];
          hold[l] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 60))
                                                : int'($urandom_range(1, 9));
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      drive(1, lvl[0], lvl[1]);
    end
    rst = 1'b0;
    drive(15, 0, 0);

    n_checks++;
    if (pq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_pulses: %0d expected pulses never observed, want 0", pq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_sensor_conditioner.md
# parking_sensor_conditioner

Front-end stage for the car park controller. Synchronises and debounces the raw entry and exit loop-detector inputs, qualifies one event per vehicle, and drives the controller's `sense_entry`/`sense_exit` inputs with clean single-cycle pulses, never both in the same cycle. It also flags loop detectors that stay occupied too long.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles needed to qualify a level change. Legal range 2..255.
- `STUCK_CYCLES`, default 200: cycles a lane may stay occupied before it faults. Legal range 1..255 and greater than `DEBOUNCE_CYCLES`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raw_entry`  in  1  entry loop detector, asynchronous, high = vehicle present.
- `raw_exit`  in  1  exit loop detector, asynchronous, high = vehicle present.
- `sense_entry`  out  1  one-cycle pulse per qualified entry arrival; feeds the controller's `sense_entry`.
- `sense_exit`  out  1  one-cycle pulse per qualified exit arrival; feeds the controller's `sense_exit`.
- `entry_busy`  out  1  entry lane FSM not in IDLE.
- `exit_busy`  out  1  exit lane FSM not in IDLE.
- `fault_entry`  out  1  entry lane in FAULT.
- `fault_exit`  out  1  exit lane in FAULT.

## Operation
- **Synchronisers:** each raw input passes through a 2-flop synchroniser; the second flop output is `s`.
- **Lane FSMs:** two identical, independent FSMs (entry, exit). Each has an 8-bit stable counter `dcnt` and an 8-bit occupancy counter `ocnt`.
- **IDLE:**
  - `s`=1 → ARMING, `dcnt`=1.
  - Otherwise stay.
- **ARMING:**
  - `s`=0 → IDLE, `dcnt`=0.
  - `s`=1 and `dcnt`=`DEBOUNCE_CYCLES`-1 → PRESENT; set the lane's pending flag; `ocnt`=0; `dcnt`=0.
  - Otherwise `dcnt`+1.
- **PRESENT:**
  - `s`=0 → `dcnt`+1; `s`=1 → `dcnt`=0.
  - `dcnt` reaches `DEBOUNCE_CYCLES`-1 with `s`=0 → IDLE.
  - `ocnt` increments every cycle and saturates at 255.
  - `ocnt`=`STUCK_CYCLES` → FAULT.
- **FAULT:**
  - Release rule is the same as PRESENT: `DEBOUNCE_CYCLES` consecutive `s`=0 → IDLE, which clears the fault output.
  - No pulse is issued on entry to or exit from FAULT.
- **Arbiter:** one pending flag per lane.
  - Each cycle: if the entry flag is set, register `sense_entry`=1 and clear that flag.
  - Else if the exit flag is set, register `sense_exit`=1 and clear that flag.
  - Entry has priority. A simultaneous exit is deferred exactly one cycle.
  - A flag can never be re-set before it is serviced, because re-qualification needs at least 2·`DEBOUNCE_CYCLES`+1 cycles.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no pulse. A drop-out in PRESENT shorter than `DEBOUNCE_CYCLES` does not re-arm the lane, so the same vehicle gets no second pulse.

## Timing
- **Reset values:** all outputs 0; synchronisers 0; FSMs IDLE; counters and pending flags 0.
- **Latency:** edge 0 is the first edge to sample `raw_*`=1. If the input stays high, the pulse is high in the cycle after edge `DEBOUNCE_CYCLES`+2 (edge 6 at default), deferred-exit case aside.
- **Pulse width:** `sense_*` are registered and high for exactly 1 cycle.
- **Exclusivity:** `sense_entry` and `sense_exit` are never high together.
- **Busy/fault outputs:** registered from FSM state; they change on the edge the state changes.
- **Reset mid-operation:** pending pulses are dropped. If a raw input is still high after `rst` deasserts, it re-qualifies like a new arrival and a new pulse is produced.

## Configuration
- Macro: `PARKING_SENSOR_STUCK_DETECT_EN`.
- **Defined:** FAULT state, `ocnt`, and `STUCK_CYCLES` behave as above.
- **Undefined:**
  - `ocnt` and FAULT are not built.
  - PRESENT waits indefinitely for release.
  - `fault_entry`/`fault_exit` are tied 0.
  - `STUCK_CYCLES` is ignored.

## Test plan
- **Clean entry:** `raw_entry` high 20 cycles, default params → `sense_entry` high for one cycle only, in the cycle after edge 6. `entry_busy` 1 until 4 low cycles after release. No `sense_exit`.
- **Glitch reject:**
  - `raw_exit` high 3 cycles → no pulse; `exit_busy` returns to 0.
  - Then a 2-cycle low dip while PRESENT → still only one pulse.
- **Simultaneous:** `raw_entry` and `raw_exit` rise on the same cycle → `sense_entry` at the edge-6 cycle, `sense_exit` at edge 7, never overlapping.
- **Stuck loop** (`PARKING_SENSOR_STUCK_DETECT_EN` defined, `STUCK_CYCLES`=20): `raw_entry` held high 100 cycles → one pulse; `fault_entry`=1 from about 20 cycles after qualification; cleared 4 cycles after the synchronised low; no extra pulse. With the macro undefined → `fault_entry` stays 0.
- **Reset mid-operation:** `rst` for 1 cycle while the entry lane is ARMING with `raw_entry` still high → all outputs 0 during reset. `sense_entry` pulses `DEBOUNCE_CYCLES`+2 edges after reset release.
